// File: rtl/ptmch_pkg.sv
// Shared types and constants for the trigger scheduler.
package ptmch_pkg;

   localparam int N_CH_C = 5;
   localparam int CODE_W = 3;
   localparam int TS_W_C = 16;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [TS_W_C-1:0] ts;
   } evt_t;

   localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/ptmch_evt_fifo.sv
// Show-ahead event log FIFO: the head entry is presented whenever the FIFO is not empty.
module ptmch_evt_fifo
   import ptmch_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                     CLK160M,
   input  logic                     RESET,
   input  logic                     push,
   input  logic [EVT_W-1:0]         push_data,
   input  logic                     pop,
   output logic [EVT_W-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   evt_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // A pop on an empty FIFO is ignored, so a same-cycle push is always kept there;
   // a pop frees the slot a same-cycle push into a full FIFO needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign level = count;
   assign head  = mem[rd_ptr];

   always_ff @(posedge CLK160M) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge CLK160M) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ptmch_trg_sched.sv
// Trigger scheduler: edge-detects per-class trigger pulses, arbitrates them round-robin
// onto one shaped scope trigger, and logs each grant with a timestamp.
module ptmch_trg_sched
   import ptmch_pkg::*;
#(
   parameter int N_CH       = N_CH_C,
   parameter int TS_W       = TS_W_C,
   parameter int FIFO_DEPTH = 8,
   parameter int CFG_W      = 8
)
(
   input  logic                          CLK160M,
   input  logic                          RESET,
   input  logic [N_CH-1:0]               TRG_IN,
   input  logic [N_CH-1:0]               CH_EN,
   input  logic [CFG_W-1:0]              PLS_WIDTH,
   input  logic [CFG_W-1:0]              GAP_CYC,
   input  logic                          CLR_STAT,
   output logic                          TRG_OUT,
   output logic [CODE_W-1:0]             TRG_CODE,
   output logic                          EVT_VALID,
   input  logic                          EVT_READY,
   output logic [CODE_W-1:0]             EVT_CODE,
   output logic [TS_W-1:0]               EVT_TS,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic [7:0]                    OVF_CNT
);

   state_t            state;
   state_t            state_nxt;
   logic [N_CH-1:0]   prev;
   logic [N_CH-1:0]   pend;
   logic [N_CH-1:0]   pend_nxt;
   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   collide;
   logic [N_CH-1:0]   grant_oh;
   logic [CODE_W-1:0] last_grant;
   logic [CODE_W-1:0] last_grant_nxt;
   logic [CODE_W-1:0] grant_idx;
   logic [CODE_W-1:0] trg_code_nxt;
   logic              grant_found;
   logic              grant;
   logic              trg_out_nxt;
   logic              evt_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              log_drop;
   logic [CFG_W-1:0]  cnt;
   logic [CFG_W-1:0]  cnt_nxt;
   logic [TS_W-1:0]   ts_cnt;
   logic [3:0]        drop_cnt;
   logic [8:0]        ovf_sum;
   evt_t              push_evt;
   evt_t              head_evt;

   assign rise     = TRG_IN & ~prev & CH_EN;
   assign collide  = rise & pend;
   assign grant    = (state == IDLE) && grant_found;
   assign grant_oh = grant ? (N_CH'(1) << grant_idx) : '0;
   assign pend_nxt = CH_EN & ((pend & ~grant_oh) | (rise & ~pend));

   // Round-robin search starting one past the last granted channel, wrapping at N_CH.
   always_comb begin
      logic [CODE_W:0]   sum;
      logic [CODE_W-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      cand        = '0;
      for (int k = 1; k <= N_CH; k++) begin
         sum = {1'b0, last_grant} + (CODE_W+1)'(k);
         if (sum >= (CODE_W+1)'(N_CH)) sum = sum - (CODE_W+1)'(N_CH);
         cand = sum[CODE_W-1:0];
         if (!grant_found && pend[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge CLK160M) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant) state_nxt = PULSE;
         PULSE:   if (cnt == '0) state_nxt = (GAP_CYC == '0) ? IDLE : GAP;
         GAP:     if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Width and gap settings are captured into the shared counter on entry to each phase.
   always_comb begin
      trg_out_nxt    = TRG_OUT;
      trg_code_nxt   = TRG_CODE;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      evt_push       = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant) begin
               trg_out_nxt    = 1'b1;
               trg_code_nxt   = grant_idx + CODE_W'(1);
               cnt_nxt        = (PLS_WIDTH == '0) ? '0 : PLS_WIDTH - CFG_W'(1);
               last_grant_nxt = grant_idx;
               evt_push       = 1'b1;
            end
         end
         PULSE: begin
            if (cnt == '0) begin
               trg_out_nxt  = 1'b0;
               trg_code_nxt = '0;
               cnt_nxt      = (GAP_CYC == '0) ? '0 : GAP_CYC - CFG_W'(1);
            end else begin
               cnt_nxt = cnt - CFG_W'(1);
            end
         end
         GAP: begin
            if (cnt != '0) cnt_nxt = cnt - CFG_W'(1);
         end
         default: begin
            trg_out_nxt  = 1'b0;
            trg_code_nxt = '0;
         end
      endcase
   end

   assign fifo_pop = EVT_READY & ~fifo_empty;
   assign log_drop = evt_push & fifo_full & ~fifo_pop;

   always_comb begin
      drop_cnt = {3'b000, log_drop};
      for (int i = 0; i < N_CH; i++) drop_cnt = drop_cnt + {3'b000, collide[i]};
   end

   assign ovf_sum = {1'b0, OVF_CNT} + {5'b00000, drop_cnt};

   // The edge detector keeps tracking TRG_IN through reset so a held input is not an edge.
   always_ff @(posedge CLK160M) begin
      prev <= TRG_IN;
   end

   always_ff @(posedge CLK160M) begin
      if (RESET) begin
         TRG_OUT    <= 1'b0;
         TRG_CODE   <= '0;
         cnt        <= '0;
         last_grant <= CODE_W'(N_CH - 1);
         pend       <= '0;
         ts_cnt     <= '0;
         OVF_CNT    <= '0;
      end else begin
         TRG_OUT    <= trg_out_nxt;
         TRG_CODE   <= trg_code_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         pend       <= pend_nxt;
         ts_cnt     <= ts_cnt + TS_W'(1);
         if (CLR_STAT)        OVF_CNT <= '0;
         else if (ovf_sum[8]) OVF_CNT <= 8'hFF;
         else                 OVF_CNT <= ovf_sum[7:0];
      end
   end

   assign push_evt = '{code: grant_idx, ts: ts_cnt};

   ptmch_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .CLK160M   (CLK160M),
      .RESET     (RESET),
      .push      (evt_push),
      .push_data (push_evt),
      .pop       (fifo_pop),
      .head      (head_evt),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (FIFO_LEVEL)
   );

   assign EVT_VALID = ~fifo_empty;
   assign EVT_CODE  = head_evt.code;
   assign EVT_TS    = head_evt.ts;

endmodule

// File: tb/tb_ptmch_trg_sched.sv
// Scoreboard bench for ptmch_trg_sched: directed stimulus queues expected pulses and
// log entries, two monitors pop and compare them as the DUT presents them.
module tb_ptmch_trg_sched;
   import ptmch_pkg::*;

   typedef struct packed {
      logic [2:0]  code;
      logic [31:0] width;
   } pls_t;

   logic        CLK160M;
   logic        RESET;
   logic [4:0]  TRG_IN;
   logic [4:0]  CH_EN;
   logic [7:0]  PLS_WIDTH;
   logic [7:0]  GAP_CYC;
   logic        CLR_STAT;
   logic        TRG_OUT;
   logic [2:0]  TRG_CODE;
   logic        EVT_VALID;
   logic        EVT_READY;
   logic [2:0]  EVT_CODE;
   logic [15:0] EVT_TS;
   logic [3:0]  FIFO_LEVEL;
   logic [7:0]  OVF_CNT;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] cyc   = 16'd0;

   pls_t expPls [$];
   evt_t expEvt [$];

   logic        inPulse    = 1'b0;
   logic        pulseAbort = 1'b0;
   int          pulseLen   = 0;
   pls_t        curPls;
   evt_t        curEvt;

   ptmch_trg_sched dut (
      .CLK160M    (CLK160M),
      .RESET      (RESET),
      .TRG_IN     (TRG_IN),
      .CH_EN      (CH_EN),
      .PLS_WIDTH  (PLS_WIDTH),
      .GAP_CYC    (GAP_CYC),
      .CLR_STAT   (CLR_STAT),
      .TRG_OUT    (TRG_OUT),
      .TRG_CODE   (TRG_CODE),
      .EVT_VALID  (EVT_VALID),
      .EVT_READY  (EVT_READY),
      .EVT_CODE   (EVT_CODE),
      .EVT_TS     (EVT_TS),
      .FIFO_LEVEL (FIFO_LEVEL),
      .OVF_CNT    (OVF_CNT)
   );

   initial CLK160M = 1'b0;
   always #5 CLK160M = ~CLK160M;

   // Bench copy of the free-running timestamp, restarted by reset.
   always @(posedge CLK160M) begin
      if (RESET) cyc <= 16'd0;
      else       cyc <= cyc + 16'd1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge CLK160M);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] ch, input int hold);
      TRG_IN[ch] = 1'b1;
      waitCycles(hold);
      TRG_IN[ch] = 1'b0;
   endtask

   function automatic evt_t mkEvt(input logic [2:0] c, input logic [15:0] t);
      evt_t e;
      e.code = c;
      e.ts   = t;
      return e;
   endfunction

   function automatic pls_t mkPls(input logic [2:0] c, input int w);
      pls_t p;
      p.code  = c;
      p.width = 32'(w);
      return p;
   endfunction

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_trg_out"},    32'(TRG_OUT),    32'd0);
      checkOutput({tag, "_trg_code"},   32'(TRG_CODE),   32'd0);
      checkOutput({tag, "_evt_valid"},  32'(EVT_VALID),  32'd0);
      checkOutput({tag, "_fifo_level"}, 32'(FIFO_LEVEL), 32'd0);
      checkOutput({tag, "_ovf_cnt"},    32'(OVF_CNT),    32'd0);
   endtask

   // Pulse monitor: code checked on the rising edge, width on the falling edge
   // unless a reset cut the pulse short.
   always @(negedge CLK160M) begin
      if (TRG_OUT === 1'b1) begin
         if (!inPulse) begin
            inPulse    = 1'b1;
            pulseLen   = 1;
            pulseAbort = 1'b0;
            checkOutput("pls_expected", 32'(expPls.size() != 0), 32'd1);
            if (expPls.size() != 0) begin
               curPls = expPls.pop_front();
               checkOutput("pls_code", 32'(TRG_CODE), 32'(curPls.code));
            end else begin
               curPls = mkPls(3'd0, 0);
            end
         end else begin
            pulseLen++;
         end
         if (RESET) pulseAbort = 1'b1;
      end else if (inPulse) begin
         inPulse = 1'b0;
         checkOutput("pls_code_low", 32'(TRG_CODE), 32'd0);
         if (!pulseAbort) checkOutput("pls_width", 32'(pulseLen), curPls.width);
      end
   end

   // Log monitor: every accepted pop is compared against the next expected entry.
   always @(negedge CLK160M) begin
      if (!RESET && EVT_VALID === 1'b1 && EVT_READY === 1'b1) begin
         checkOutput("evt_expected", 32'(expEvt.size() != 0), 32'd1);
         if (expEvt.size() != 0) begin
            curEvt = expEvt.pop_front();
            checkOutput("evt_code", 32'(EVT_CODE), 32'(curEvt.code));
            checkOutput("evt_ts",   32'(EVT_TS),   32'(curEvt.ts));
         end
      end
   end

   initial begin
      RESET     = 1'b1;
      TRG_IN    = '0;
      CH_EN     = '1;
      PLS_WIDTH = 8'd4;
      GAP_CYC   = 8'd2;
      CLR_STAT  = 1'b0;
      EVT_READY = 1'b1;
      waitCycles(2);
      RESET = 1'b0;
      checkResetState("reset");
      waitCycles(3);

      // Single event: grant two edges after the input edge, width 4, code 3.
      expPls.push_back(mkPls(3'd3, 4));
      expEvt.push_back(mkEvt(3'd2, cyc + 16'd1));
      TRG_IN[2] = 1'b1;
      waitCycles(1);
      checkOutput("single_not_yet", 32'(TRG_OUT), 32'd0);
      waitCycles(1);
      checkOutput("single_out",  32'(TRG_OUT),  32'd1);
      checkOutput("single_code", 32'(TRG_CODE), 32'd3);
      waitCycles(14);
      TRG_IN[2] = 1'b0;
      waitCycles(10);

      // Round-robin between ch0 and ch1 with minimum width and no gap.
      PLS_WIDTH = 8'd1;
      GAP_CYC   = 8'd0;
      for (int r = 0; r < 2; r++) begin
         expPls.push_back(mkPls(3'd1, 1));
         expPls.push_back(mkPls(3'd2, 1));
         expEvt.push_back(mkEvt(3'd0, cyc + 16'd1));
         expEvt.push_back(mkEvt(3'd1, cyc + 16'd3));
         TRG_IN[1:0] = 2'b11;
         waitCycles(2);
         for (int p = 0; p < 4; p++) begin
            checkOutput("rr_out",  32'(TRG_OUT),  (p % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_code", 32'(TRG_CODE), (p == 0) ? 32'd1 : (p == 2) ? 32'd2 : 32'd0);
            waitCycles(1);
         end
         waitCycles(10);
         TRG_IN[1:0] = 2'b00;
         waitCycles(6);
      end

      // Collision: ch3 rises twice during a long ch0 pulse; width change after grant is ignored.
      PLS_WIDTH = 8'd200;
      GAP_CYC   = 8'd0;
      expPls.push_back(mkPls(3'd1, 200));
      expPls.push_back(mkPls(3'd4, 3));
      expEvt.push_back(mkEvt(3'd0, cyc + 16'd1));
      expEvt.push_back(mkEvt(3'd3, cyc + 16'd202));
      TRG_IN[0] = 1'b1;
      waitCycles(2);
      PLS_WIDTH = 8'd3;
      waitCycles(14);
      TRG_IN[0] = 1'b0;
      waitCycles(4);
      applyStimulus(3'd3, 16);
      waitCycles(8);
      applyStimulus(3'd3, 16);
      waitCycles(160);
      checkOutput("coll_ovf", 32'(OVF_CNT), 32'd1);
      CLR_STAT = 1'b1;
      waitCycles(1);
      CLR_STAT = 1'b0;
      checkOutput("clr_ovf", 32'(OVF_CNT), 32'd0);
      waitCycles(5);

      // FIFO full: nine logged grants with no readout, the ninth entry is dropped.
      PLS_WIDTH = 8'd2;
      GAP_CYC   = 8'd1;
      EVT_READY = 1'b0;
      for (int n = 0; n < 9; n++) begin
         logic [2:0] ch;
         ch = 3'(n % 5);
         expPls.push_back(mkPls(ch + 3'd1, 2));
         if (n < 8) expEvt.push_back(mkEvt(ch, cyc + 16'd1));
         applyStimulus(ch, 16);
         waitCycles(4);
      end
      checkOutput("full_level", 32'(FIFO_LEVEL), 32'd8);
      checkOutput("full_ovf",   32'(OVF_CNT),    32'd1);
      checkOutput("full_valid", 32'(EVT_VALID),  32'd1);
      EVT_READY = 1'b1;
      waitCycles(12);
      checkOutput("drain_level", 32'(FIFO_LEVEL), 32'd0);
      checkOutput("drain_valid", 32'(EVT_VALID),  32'd0);
      CLR_STAT = 1'b1;
      waitCycles(1);
      CLR_STAT = 1'b0;
      waitCycles(4);

      // Disabling ch1 while it is pending drops it without disturbing the ch0 pulse.
      PLS_WIDTH = 8'd10;
      GAP_CYC   = 8'd0;
      expPls.push_back(mkPls(3'd1, 10));
      expEvt.push_back(mkEvt(3'd0, cyc + 16'd1));
      TRG_IN[0] = 1'b1;
      waitCycles(4);
      TRG_IN[1] = 1'b1;
      waitCycles(2);
      CH_EN[1] = 1'b0;
      waitCycles(1);
      checkOutput("chen_no_abort_out",  32'(TRG_OUT),  32'd1);
      checkOutput("chen_no_abort_code", 32'(TRG_CODE), 32'd1);
      waitCycles(9);
      TRG_IN[1:0] = 2'b00;
      waitCycles(6);
      CH_EN[1] = 1'b1;
      checkOutput("chen_ovf", 32'(OVF_CNT), 32'd0);
      waitCycles(10);

      // Reset in the middle of a ch4 pulse with TRG_IN[4] held high through release.
      PLS_WIDTH = 8'd20;
      GAP_CYC   = 8'd0;
      expPls.push_back(mkPls(3'd5, 0));
      expEvt.push_back(mkEvt(3'd4, cyc + 16'd1));
      TRG_IN[4] = 1'b1;
      waitCycles(6);
      checkOutput("rst_pre_out", 32'(TRG_OUT), 32'd1);
      RESET = 1'b1;
      waitCycles(1);
      checkResetState("midrst");
      RESET = 1'b0;
      waitCycles(9);
      TRG_IN[4] = 1'b0;
      checkOutput("rst_no_evt", 32'(EVT_VALID), 32'd0);
      waitCycles(3);
      PLS_WIDTH = 8'd3;
      expPls.push_back(mkPls(3'd5, 3));
      expEvt.push_back(mkEvt(3'd4, cyc + 16'd1));
      applyStimulus(3'd4, 16);
      waitCycles(10);

      checkOutput("pls_queue_empty", 32'(expPls.size()), 32'd0);
      checkOutput("evt_queue_empty", 32'(expEvt.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
